siso_frame_ctrl: RTL
====================

// Module: siso_frame_ctrl
// PURPOSE
//  Sequences a SISO shift-register datapath: accepts parallel words over a valid/ready
//  handshake, loads the internal shift register, shifts WIDTH bits out serially under
//  downstream flow control, then inserts a programmable idle gap before the next frame.
//  Sits between a word-level producer and a bit-serial consumer (serial link/test chain).
// PARAMETERS
//  WIDTH      8  bits per frame; legal 2..32
//  GAP        1  idle cycles after each frame before in_ready re-asserts; legal 0..15
//  MSB_FIRST  0  0: right shift, bit0 first; 1: left shift, bit WIDTH-1 first
// PORTS
//  clk        in   1      single clock; all state updates on posedge clk
//  rst_n      in   1      reset; asynchronous and active-low
//  in_data    in   WIDTH  parallel word to serialise
//  in_valid   in   1      producer has a word
//  in_ready   out  1      controller can accept a word this cycle
//  abort      in   1      synchronous frame abort
//  s_out      out  1      current serial bit
//  s_valid    out  1      s_out holds a frame bit
//  s_ready    in   1      consumer takes s_out this cycle
//  s_last     out  1      s_out is the final bit of the frame
//  busy       out  1      state != IDLE
//  frame_done out  1      1-cycle pulse: frame fully shifted out
// BEHAVIOUR
//  - rst_n low: state IDLE, shift reg 0, bit/gap counters 0, s_out 0, s_valid 0, s_last 0,
//    busy 0, frame_done 0, in_ready 1 (decoded from IDLE). Reset mid-frame drops the frame.
//  - States: IDLE -> SHIFT -> (GAP if GAP>0) -> IDLE.
//  - IDLE: in_ready = ~abort. Accept on in_valid & in_ready: load in_data, cnt<=0, ->SHIFT.
//    First bit on s_out the cycle after acceptance (latency 1).
//  - SHIFT: s_valid 1; s_out = sreg[0] (MSB_FIRST=0) or sreg[WIDTH-1] (MSB_FIRST=1).
//    Bit consumed on s_valid & s_ready: shift one place (zero fill), cnt++.
//    s_ready low: sreg, cnt, s_out held (no bit lost or repeated).
//    s_last = (cnt == WIDTH-1). Last bit consumed -> GAP (GAP>0) or IDLE (GAP=0);
//    frame_done pulses the following cycle.
//  - GAP: s_valid 0, in_ready 0; counts GAP cycles then -> IDLE.
//  - in_ready only in IDLE: minimum frame period WIDTH+GAP+1 cycles with s_ready held 1.
//  - abort (any state, priority over accept and shift): next cycle IDLE, sreg 0, cnt 0,
//    s_valid 0, no frame_done. abort with in_valid in IDLE: word not accepted.
//  - s_out = 0 whenever s_valid = 0.
//  - cnt width $clog2(WIDTH); gap counter width $clog2(GAP+1) (min 1). No wrap: cnt
//    never exceeds WIDTH-1.
//  - in_data sampled only on the accept edge; changes at other times ignored.
// STRUCTURE
//  - siso_frame_pkg: state encoding localparams (ST_IDLE, ST_SHIFT, ST_GAP, 2-bit),
//    parameter legality limits.
//  - Sub-module shift_core: WIDTH-bit register with load/shift_en/clear inputs, direction
//    per MSB_FIRST, serial bit output. FSM + counters stay in siso_frame_ctrl.
// TESTING (WIDTH=8, GAP=1 unless stated; accept edge = E0)
//  1. Reset: rst_n low during bit 3 of a frame -> s_valid/s_out/busy 0 immediately,
//     in_ready 1; after release, no residual bits emitted.
//  2. in_data=8'hA5, s_ready=1 -> s_out 1,0,1,0,0,1,0,1 in cycles after E0..E7; s_last on
//     8th bit; frame_done pulse after E8; in_ready 1 again after E9.
//  3. 8'hA5, s_ready low 3 cycles while bit3 presented -> bit3 held 4 cycles, sequence
//     unchanged, last bit after E10.
//  4. abort asserted while bit5 presented -> next cycle s_valid 0, in_ready 1, no
//     frame_done; new word 8'h3C then serialises correctly from bit0.
//  5. MSB_FIRST=1, in_data=8'hC0 -> s_out 1,1,0,0,0,0,0,0.
//  6. GAP=0, in_valid held 1 with 8'hFF then 8'h00 -> 8 ones, one idle cycle, 8 zeros;
//     second word accepted at E9.

Source files
------------

// File: rtl/siso_frame_pkg.sv
// ---------------------------------------------------------------------------
// siso_frame_pkg
//   Shared definitions for the SISO frame controller: FSM state encoding,
//   legal parameter ranges and a counter-width helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package siso_frame_pkg;

   // Controller states, 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Legal parameter ranges.
   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;
   localparam int GAP_MIN   = 0;
   localparam int GAP_MAX   = 15;

   // The gap counter must hold values 0..GAP-1.
   // When GAP is 0 it is never used, but it keeps a legal width of 1.
   function automatic int gap_cnt_width(input int gap);
      return (gap < 1) ? 1 : $clog2(gap + 1);
   endfunction

endpackage

// File: rtl/siso_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// siso_frame_ctrl_if
//   Bundles the word-side handshake, the bit-serial side and the status
//   outputs of the SISO frame controller.
//   Signals:
//     in_data/in_valid/in_ready  word producer handshake
//     abort                      synchronous frame abort
//     s_out/s_valid/s_ready      serial bit handshake, s_last marks final bit
//     busy/frame_done            status
//   Modports:
//     master  producer + consumer side (drives in_*, abort, s_ready)
//     slave   the controller
// ---------------------------------------------------------------------------
interface siso_frame_ctrl_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             abort;
   logic             s_out;
   logic             s_valid;
   logic             s_ready;
   logic             s_last;
   logic             busy;
   logic             frame_done;

   modport master (
      output in_data, in_valid, abort, s_ready,
      input  in_ready, s_out, s_valid, s_last, busy, frame_done
   );

   modport slave (
      input  in_data, in_valid, abort, s_ready,
      output in_ready, s_out, s_valid, s_last, busy, frame_done
   );
endinterface

// File: rtl/siso_frame_ctrl_shift_core.sv
// ---------------------------------------------------------------------------
// shift_core
//   WIDTH-bit shift register for the frame controller. It is cleared, loaded
//   in parallel, or shifted by one place with zero fill. The direction is
//   set by MSB_FIRST.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     i_clear       clear to zero (highest priority)
//     i_load        parallel load of i_data
//     i_shift_en    shift one place toward the serial output
//     i_data        parallel word
//     o_bit         bit currently at the serial output end
// ---------------------------------------------------------------------------
module shift_core #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic             i_shift_en,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_bit
);

   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] w_shifted;

   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
         assign o_bit     = r_sreg[WIDTH-1];
      end else begin : g_lsb_first
         assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
         assign o_bit     = r_sreg[0];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sreg <= '0;
      end else if (i_clear) begin
         r_sreg <= '0;
      end else if (i_load) begin
         r_sreg <= i_data;
      end else if (i_shift_en) begin
         r_sreg <= w_shifted;
      end
   end

endmodule

// File: rtl/siso_frame_ctrl.sv
// ---------------------------------------------------------------------------
// siso_frame_ctrl
//   Takes parallel words over a valid/ready handshake and shifts each one out
//   as WIDTH serial bits under s_ready flow control. After each frame it
//   inserts GAP idle cycles before it accepts the next word. abort drops the
//   current frame and returns the controller to IDLE on the next edge.
//   Ports:
//     clk    clock (rising edge)
//     rst_n  asynchronous active-low reset
//     bus    siso_frame_ctrl_if.slave carrying in_data/in_valid/in_ready,
//            abort, s_out/s_valid/s_ready/s_last, busy, frame_done
//   Parameters: WIDTH (2..32), GAP (0..15), MSB_FIRST (0/1)
// ---------------------------------------------------------------------------
module siso_frame_ctrl
   import siso_frame_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int GAP       = 1,
   parameter int MSB_FIRST = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   siso_frame_ctrl_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);
   localparam int GW = gap_cnt_width(GAP);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [GW-1:0]  r_gap_cnt;
   logic           r_s_valid;
   logic           r_s_last;
   logic           r_busy;
   logic           r_frame_done;

   logic           w_accept;
   logic           w_consume;
   logic           w_core_bit;

   // abort wins over both accept and shift, so it gates the datapath strobes.
   assign w_accept  = (r_state == ST_IDLE)  & bus.in_valid & ~bus.abort;
   assign w_consume = (r_state == ST_SHIFT) & bus.s_ready  & ~bus.abort;

   shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (bus.abort),
      .i_load     (w_accept),
      .i_shift_en (w_consume),
      .i_data     (bus.in_data),
      .o_bit      (w_core_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_gap_cnt    <= '0;
         r_s_valid    <= 1'b0;
         r_s_last     <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (bus.abort) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            r_s_valid <= 1'b0;
            r_s_last  <= 1'b0;
            r_busy    <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.in_valid) begin
                     r_state   <= ST_SHIFT;
                     r_cnt     <= '0;
                     r_s_valid <= 1'b1;
                     r_s_last  <= 1'b0;
                     r_busy    <= 1'b1;
                  end
               end
               ST_SHIFT: begin
                  if (bus.s_ready) begin
                     if (r_cnt == CNT_LAST) begin
                        // Final bit taken. Counter returns to 0, so it never wraps.
                        r_cnt        <= '0;
                        r_s_valid    <= 1'b0;
                        r_s_last     <= 1'b0;
                        r_frame_done <= 1'b1;
                        if (GAP > 0) begin
                           r_state   <= ST_GAP;
                           r_gap_cnt <= '0;
                        end else begin
                           r_state <= ST_IDLE;
                           r_busy  <= 1'b0;
                        end
                     end else begin
                        r_cnt    <= r_cnt + CW'(1);
                        // s_last is registered: it rises as the last bit reaches s_out.
                        r_s_last <= ((r_cnt + CW'(1)) == CNT_LAST);
                     end
                  end
               end
               ST_GAP: begin
                  if (r_gap_cnt == GAP_LAST) begin
                     r_state   <= ST_IDLE;
                     r_gap_cnt <= '0;
                     r_busy    <= 1'b0;
                  end else begin
                     r_gap_cnt <= r_gap_cnt + GW'(1);
                  end
               end
               default: begin
                  r_state   <= ST_IDLE;
                  r_cnt     <= '0;
                  r_gap_cnt <= '0;
                  r_s_valid <= 1'b0;
                  r_s_last  <= 1'b0;
                  r_busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   // in_ready must drop in the same cycle abort is raised, so it is decoded
   // combinationally from the registered state.
   assign bus.in_ready   = (r_state == ST_IDLE) & ~bus.abort;
   assign bus.s_out      = r_s_valid & w_core_bit;
   assign bus.s_valid    = r_s_valid;
   assign bus.s_last     = r_s_last;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_frame_done;

endmodule
